spi_word_host: RTL and testbench
================================

SPI_WORD_HOST -- requirements
Module: spi_word_host

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per SCLK half-period; legal range 1..255; 0 is illegal.
REQ-002 Parameter FRAME_BITS, fixed 32, frame length {cmd[3:0], addr[11:0], data[15:0]}; not user-overridable.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to launch a frame; sampled only in IDLE.
REQ-006 rw  input  1  1 = write frame, 0 = read frame; sampled with start.
REQ-007 addr  input  12  target word address; sampled with start.
REQ-008 wdata  input  16  write payload; sampled with start, also sent on reads.
REQ-009 busy  output  1  high from the cycle after start is accepted until the frame ends.
REQ-010 done  output  1  one-cycle pulse at frame end.
REQ-011 rdata  output  16  last 16 MISO bits of the most recent frame.
REQ-012 spi_cs_n  output  1  chip select, active-low.
REQ-013 spi_sclk  output  1  serial clock, idle low (mode 0).
REQ-014 spi_mosi  output  1  serial data out, MSB first.
REQ-015 spi_miso  input  1  serial data in from responder.

Function
REQ-016 FSM states IDLE, SETUP, SHIFT, HOLD; IDLE->SETUP on start, SETUP->SHIFT after CLK_DIV cycles, SHIFT->HOLD after 32 SCLK periods, HOLD->IDLE after CLK_DIV cycles.
REQ-017 On accepted start, the shift register loads {cmd, addr, wdata}, with cmd = 4'b1010 when rw=1 and 4'b0101 when rw=0.
REQ-018 SETUP: spi_cs_n low, spi_sclk low, spi_mosi = frame bit 31.
REQ-019 SHIFT: spi_sclk toggles every CLK_DIV cycles, starting low; exactly 32 rising edges per frame.
REQ-020 spi_mosi changes only on SCLK falling edges (and on SETUP entry); spi_miso is sampled on SCLK rising edges.
REQ-021 HOLD: spi_sclk low, spi_cs_n low; spi_cs_n rises on the HOLD->IDLE transition.
REQ-022 Total busy duration is exactly 66*CLK_DIV clk cycles.
REQ-023 done pulses in the cycle spi_cs_n returns high; busy falls in the same cycle.
REQ-024 rdata updates only at frame end and holds between frames.
REQ-025 start while busy is ignored, with no queueing.
REQ-026 start asserted in the same cycle done pulses is ignored; the next start is accepted one cycle later, in IDLE.
REQ-027 In IDLE: spi_cs_n=1, spi_sclk=0, spi_mosi=0.
REQ-028 The divider counter is 8 bits; it resets to 0 at each half-period boundary and never wraps otherwise.

Reset
REQ-029 rst_n low forces, immediately and asynchronously: state IDLE, busy=0, done=0, rdata=0, spi_cs_n=1, spi_sclk=0, spi_mosi=0, and clears all counters.
REQ-030 Reset asserted mid-frame aborts the frame without a done pulse; the first start after reset release launches a complete new frame.

Configuration
REQ-031 Macro SPI_READBACK_EN defined: spi_miso is shifted in and rdata is updated per REQ-024.
REQ-032 Macro SPI_READBACK_EN undefined: spi_miso is ignored, rdata is tied to 16'h0000, and no capture register is synthesised; all other timing is identical.

Verification
REQ-033 CLK_DIV=2, start with rw=1, addr=12'h123, wdata=16'hABCD -> MOSI sampled at SCLK rising edges = 32'hA123ABCD, busy high for 132 cycles, one done pulse.
REQ-034 CLK_DIV=1, rw=0, addr=12'h0FF, MISO driven 32'h0000BEEF (readback enabled) -> MOSI = 32'h50FF_wdata, rdata=16'hBEEF after done.
REQ-035 Extra start pulses mid-frame and in the done cycle -> exactly one frame, no extra SCLK edges, the following start accepted normally.
REQ-036 rst_n low at SCLK edge 10 of a frame -> same-cycle spi_cs_n=1 and spi_sclk=0, no done pulse, rdata=0; next frame correct.
REQ-037 SPI_READBACK_EN undefined, MISO toggling -> rdata stays 16'h0000 and MOSI/timing match REQ-033.

Source files
------------

// File: rtl/spi_word_host_if.sv
// Host-side request/response bundle for spi_word_host.
// The master modport issues frames; the slave modport is the SPI host engine.
interface spi_word_host_if;
    logic        start;
    logic        rw;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic [15:0] rdata;

    modport master (
        output start, rw, addr, wdata,
        input  busy, done, rdata
    );

    modport slave (
        input  start, rw, addr, wdata,
        output busy, done, rdata
    );
endinterface

// File: rtl/spi_word_host.sv
// SPI mode-0 host sending one 32-bit {cmd, addr, data} frame per start request.
// Optional MISO readback into rdata is enabled by defining SPI_READBACK_EN.
module spi_word_host #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_word_host_if.slave host,
    output logic          spi_cs_n,
    output logic          spi_sclk,
    output logic          spi_mosi,
    input  logic          spi_miso
);
    localparam int unsigned FRAME_BITS = 32;
    localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [5:0]  HALF_LAST  = 6'(2 * FRAME_BITS - 1);
    localparam logic [3:0]  CMD_WR     = 4'b1010;
    localparam logic [3:0]  CMD_RD     = 4'b0101;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  div_cnt_reg, div_cnt_next;
    logic [5:0]  half_cnt_reg, half_cnt_next;
    logic [31:0] frame_reg, frame_next;
    logic        sclk_reg, sclk_next;
    logic        mosi_reg, mosi_next;
    logic        done_reg, done_next;

    logic        div_tick;
    logic        sample;
    logic        frame_end;
    logic [31:0] frame_load;

    assign div_tick   = (div_cnt_reg == DIV_LAST);
    assign sample     = (state_reg == SHIFT) && div_tick && !sclk_reg;
    assign frame_end  = (state_reg == HOLD) && div_tick;
    assign frame_load = {(host.rw ? CMD_WR : CMD_RD), host.addr, host.wdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            div_cnt_reg  <= '0;
            half_cnt_reg <= '0;
            frame_reg    <= '0;
            sclk_reg     <= 1'b0;
            mosi_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            div_cnt_reg  <= div_cnt_next;
            half_cnt_reg <= half_cnt_next;
            frame_reg    <= frame_next;
            sclk_reg     <= sclk_next;
            mosi_reg     <= mosi_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        div_cnt_next  = div_cnt_reg;
        half_cnt_next = half_cnt_reg;
        frame_next    = frame_reg;
        sclk_next     = sclk_reg;
        mosi_next     = mosi_reg;
        done_next     = 1'b0;

        if (state_reg != IDLE) begin
            div_cnt_next = div_tick ? 8'd0 : div_cnt_reg + 8'd1;
        end

        case (state_reg)
            IDLE: begin
                div_cnt_next  = '0;
                half_cnt_next = '0;
                sclk_next     = 1'b0;
                mosi_next     = 1'b0;
                // A start coinciding with the done pulse is deliberately dropped.
                if (host.start && !done_reg) begin
                    frame_next = frame_load;
                    mosi_next  = frame_load[31];
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (div_tick) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (div_tick) begin
                    half_cnt_next = half_cnt_reg + 6'd1;
                    sclk_next     = ~sclk_reg;
                    if (sclk_reg) begin
                        frame_next = {frame_reg[30:0], 1'b0};
                        mosi_next  = frame_reg[30];
                    end
                    if (half_cnt_reg == HALF_LAST) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (div_tick) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    mosi_next  = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign host.busy = (state_reg != IDLE);
    assign host.done = done_reg;
    assign spi_cs_n  = (state_reg == IDLE);
    assign spi_sclk  = sclk_reg;
    assign spi_mosi  = mosi_reg;

`ifdef SPI_READBACK_EN
    logic [15:0] rx_reg, rx_next;
    logic [15:0] rdata_reg, rdata_next;

    always_comb begin
        rx_next    = rx_reg;
        rdata_next = rdata_reg;
        if (sample) begin
            rx_next = {rx_reg[14:0], spi_miso};
        end
        if (frame_end) begin
            rdata_next = rx_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_reg    <= '0;
            rdata_reg <= '0;
        end else begin
            rx_reg    <= rx_next;
            rdata_reg <= rdata_next;
        end
    end

    assign host.rdata = rdata_reg;
`else
    logic miso_unused;

    assign miso_unused = spi_miso ^ sample ^ frame_end;
    assign host.rdata  = 16'h0000;
`endif
endmodule

// File: tb/tb_spi_word_host.sv
// Scoreboard bench for spi_word_host: driver pushes expected frames, a monitor
// checks each done pulse against a responder that records MOSI and plays MISO.
module tb_spi_word_host;
    localparam int unsigned CD       = 2;
    localparam int unsigned BUSY_LEN = 66 * CD;
`ifdef SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    typedef struct {
        logic [31:0] mosi;
        logic [15:0] rdata;
        int unsigned start_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic spi_cs_n, spi_sclk, spi_mosi, spi_miso;

    spi_word_host_if bus ();

    spi_word_host #(.CLK_DIV(CD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .host     (bus),
        .spi_cs_n (spi_cs_n),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned n_frames = 0;
    exp_t sb_q[$];
    logic [15:0] last_rdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Responder: records MOSI on SCLK rise, shifts MISO on SCLK fall.
    logic [31:0] resp_pat = '0;
    logic [31:0] miso_word = '0;
    logic [31:0] mosi_word = '0;
    int unsigned rise_cnt = 0;
    logic cs_q = 1'b1;
    logic sclk_q = 1'b0;

    always @(spi_cs_n or spi_sclk) begin
        if (cs_q && !spi_cs_n) begin
            rise_cnt  = 0;
            mosi_word = '0;
            miso_word = resp_pat;
        end
        if (!sclk_q && spi_sclk) begin
            mosi_word = {mosi_word[30:0], spi_mosi};
            rise_cnt++;
        end
        if (sclk_q && !spi_sclk) begin
            miso_word = {miso_word[30:0], 1'b0};
        end
        cs_q   = spi_cs_n;
        sclk_q = spi_sclk;
    end

    assign spi_miso = miso_word[31];

    // Monitor: pin sanity every cycle, full frame comparison on each done.
    int unsigned busy_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0;
            sb_q.delete();
        end else begin
            if (bus.busy) begin
                busy_cnt++;
                check("cs_active", {31'd0, spi_cs_n}, 32'd0);
            end else begin
                check("idle_pins", {29'd0, spi_cs_n, spi_sclk, spi_mosi}, 32'd4);
            end
            if (bus.done) begin
                check("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    n_frames++;
                    check("mosi_word", mosi_word, e.mosi);
                    check("sclk_rises", rise_cnt, 32'd32);
                    check("busy_len", busy_cnt, BUSY_LEN);
                    check("done_latency", cyc - e.start_cyc, BUSY_LEN);
                    check("rdata", {16'd0, bus.rdata}, {16'd0, e.rdata});
                    check("busy_at_done", {31'd0, bus.busy}, 32'd0);
                    $display("frame %0d: mosi=%h rdata=%h busy_cycles=%0d", n_frames, mosi_word, bus.rdata, busy_cnt);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic run_frame(input logic rw_i, input logic [11:0] a, input logic [15:0] wd,
                             input logic [31:0] pat, input bit extra_mid, input bit extra_done);
        exp_t e;
        int unsigned m;
        int unsigned left;
        check("rdata_hold", {16'd0, bus.rdata}, {16'd0, last_rdata});
        resp_pat  = pat;
        bus.rw    = rw_i;
        bus.addr  = a;
        bus.wdata = wd;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        e.mosi      = {(rw_i ? 4'hA : 4'h5), a, wd};
        e.rdata     = RB ? pat[15:0] : 16'h0000;
        e.start_cyc = cyc;
        sb_q.push_back(e);
        last_rdata = e.rdata;
        left = BUSY_LEN;
        if (extra_mid) begin
            m = $urandom_range(1, BUSY_LEN - 3);
            repeat (m) @(negedge clk);
            bus.start = 1'b1;
            bus.rw    = 1'($urandom);
            bus.addr  = 12'($urandom);
            bus.wdata = 16'($urandom);
            @(negedge clk);
            bus.start = 1'b0;
            left = BUSY_LEN - m - 1;
        end
        repeat (left) @(negedge clk);
        // Now in the done cycle.
        if (extra_done) begin
            bus.start = 1'b1;
            bus.rw    = 1'($urandom);
            bus.addr  = 12'($urandom);
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.rw    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, bus.busy}, 32'd0);
        check("rst_done",  {31'd0, bus.done}, 32'd0);
        check("rst_rdata", {16'd0, bus.rdata}, 32'd0);
        check("rst_pins",  {29'd0, spi_cs_n, spi_sclk, spi_mosi}, 32'd4);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(1'b1, 12'h123, 16'hABCD, $urandom, 1'b0, 1'b0);
        run_frame(1'b0, 12'h0FF, 16'($urandom), 32'h0000BEEF, 1'b0, 1'b0);
        run_frame(1'b1, 12'($urandom), 16'($urandom), $urandom, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            run_frame(1'($urandom), 12'($urandom), 16'($urandom), $urandom,
                      1'($urandom), 1'($urandom));
        end

        // Abort a frame with reset at the tenth SCLK rise.
        resp_pat  = $urandom;
        bus.rw    = 1'b1;
        bus.addr  = 12'h3C5;
        bus.wdata = 16'h5AA5;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (rise_cnt >= 10) break;
            @(negedge clk);
        end
        check("abort_reached_edge10", {31'd0, rise_cnt >= 10}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check("abort_sclk", {31'd0, spi_sclk}, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_rdata", {16'd0, bus.rdata}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        last_rdata = 16'h0000;
        @(negedge clk);

        run_frame(1'b0, 12'h456, 16'h1357, $urandom, 1'b0, 1'b0);
        run_frame(1'($urandom), 12'($urandom), 16'($urandom), $urandom, 1'b1, 1'b0);

        for (int k = 0; k < 1000; k++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        check("sb_drained", sb_q.size(), 32'd0);
        check("frames_seen", n_frames, 32'd13);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d frames, expected 13", n_frames);
        $fatal(1, "watchdog expired");
    end
endmodule
